// File: rtl/add_tree_sched.sv
// Scheduler/accumulator for the 16-lane pipelined adder tree: feeds vectors in,
// tracks real beats through the tree latency and sums pPASSES tree results per output word.
module add_tree_sched #(
  parameter int unsigned pDATA_W = 8,
  parameter int unsigned pSUM_W  = 12,
  parameter int unsigned pLAT    = 4,
  parameter int unsigned pPASSES = 4,
  parameter int unsigned pACC_W  = 16
) (
  input  logic                  iclk,
  input  logic                  irst,
  input  logic                  ivalid,
  output logic                  oready,
  input  logic [16*pDATA_W-1:0] idata,
  input  logic                  iflush,
  output logic                  otree_en,
  output logic [16*pDATA_W-1:0] otree_data,
  input  logic [pSUM_W-1:0]     itree_sum,
  output logic                  ovalid,
  input  logic                  iready,
  output logic [pACC_W-1:0]     oacc,
  output logic [3:0]            opass,
  output logic [15:0]           ocount
);

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  state_t            state;
  logic [pLAT-1:0]   vld;
  logic [pLAT-1:0]   vld_nx;
  logic [3:0]        pass_cnt;
  logic [pACC_W-1:0] acc;
  logic [pACC_W-1:0] acc_nx;
  logic              stall;
  logic              accept;
  logic              sum_vld;
  logic              last_pass;
  logic              drained;

  always_comb begin
    stall      = ovalid & ~iready;
    otree_en   = ~stall & ~irst;
    oready     = ~stall & ~iflush & ~irst;
    accept     = ivalid & oready;
    otree_data = idata;
    sum_vld    = otree_en & vld[pLAT-1];
    last_pass  = (pass_cnt == 4'(pPASSES - 1));
    acc_nx     = (pass_cnt == '0) ? pACC_W'(itree_sum) : acc + pACC_W'(itree_sum);
    drained    = (vld == '0) & ~accept & (pass_cnt == '0) & ~ovalid;
    vld_nx[0]  = accept;
    for (int unsigned i = 1; i < pLAT; i++) vld_nx[i] = vld[i-1];
  end

  assign opass = pass_cnt;

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      vld      <= '0;
      pass_cnt <= '0;
      acc      <= '0;
      ovalid   <= 1'b0;
      oacc     <= '0;
      ocount   <= '0;
      state    <= IDLE;
    end else if (iflush) begin
      vld      <= '0;
      pass_cnt <= '0;
      acc      <= '0;
      ovalid   <= 1'b0;
      state    <= IDLE;
    end else begin
      if (ovalid && iready) begin
        ovalid <= 1'b0;
        ocount <= ocount + 16'd1;
      end
      if (otree_en) vld <= vld_nx;
      // A completing final pass overrides the drain clear above, so a draining
      // output register is refilled on the same edge.
      if (sum_vld) begin
        if (last_pass) begin
          oacc     <= acc_nx;
          ovalid   <= 1'b1;
          pass_cnt <= '0;
        end else begin
          acc      <= acc_nx;
          pass_cnt <= pass_cnt + 4'd1;
        end
      end
      case (state)
        IDLE:    if (accept) state <= BUSY;
        BUSY: begin
          if (stall)        state <= HOLD;
          else if (drained) state <= IDLE;
        end
        HOLD:    if (iready) state <= BUSY;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add_tree_sched.sv
// Scoreboard bench for add_tree_sched: ideal adder-tree model, reference accumulation
// of accepted vectors per group, and a negedge monitor comparing delivered results.
module tb_add_tree_sched;
  localparam int unsigned DW  = 8;
  localparam int unsigned SW  = 12;
  localparam int unsigned LAT = 4;
  localparam int unsigned NP  = 4;
  localparam int unsigned AW  = 16;

  logic              iclk = 1'b0;
  logic              irst, ivalid, oready, iflush, otree_en, ovalid, iready;
  logic [16*DW-1:0]  idata, otree_data;
  logic [SW-1:0]     itree_sum;
  logic [AW-1:0]     oacc;
  logic [3:0]        opass;
  logic [15:0]       ocount;

  always #5 iclk = ~iclk;

  add_tree_sched #(.pDATA_W(DW), .pSUM_W(SW), .pLAT(LAT), .pPASSES(NP), .pACC_W(AW)) dut (
    .iclk(iclk), .irst(irst), .ivalid(ivalid), .oready(oready), .idata(idata),
    .iflush(iflush), .otree_en(otree_en), .otree_data(otree_data), .itree_sum(itree_sum),
    .ovalid(ovalid), .iready(iready), .oacc(oacc), .opass(opass), .ocount(ocount)
  );

  function automatic int lanesum(input logic [16*DW-1:0] v);
    int s = 0;
    for (int k = 0; k < 16; k++) s += int'(v[k*DW +: DW]);
    return s;
  endfunction

  function automatic logic [16*DW-1:0] splat(input int val);
    logic [16*DW-1:0] v;
    for (int k = 0; k < 16; k++) v[k*DW +: DW] = DW'(val);
    return v;
  endfunction

  function automatic logic [16*DW-1:0] rand_vec();
    logic [16*DW-1:0] v;
    for (int k = 0; k < 16; k++) v[k*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  // Ideal adder tree: full lane sum delayed by LAT enabled clocks.
  logic [SW-1:0] pipe [LAT];
  always @(posedge iclk) begin
    if (otree_en) begin
      for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
      pipe[0] <= SW'(lanesum(otree_data));
    end
  end
  assign itree_sum = pipe[LAT-1];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  int     beats[$];
  longint expq[$];
  int     ocnt_m = 0;
  int     ndeliv = 0;
  longint last_out = 0;
  int     cyc = 0;
  bit     hold_prev = 1'b0;
  logic [AW-1:0] held = '0;

  always @(posedge iclk) cyc <= cyc + 1;

  function automatic longint qsum(input int q[$]);
    longint s = 0;
    foreach (q[i]) s += q[i];
    return s;
  endfunction

  // Monitor/scoreboard: every decision here concerns the upcoming rising edge.
  always @(negedge iclk) begin
    if (irst) begin
      beats.delete();
      expq.delete();
      ocnt_m    = 0;
      hold_prev = 1'b0;
    end else begin
      chk("tree_en", otree_en, !(ovalid && !iready));
      chk("oready", oready, !(ovalid && !iready) && !iflush);
      if (hold_prev) chk("hold_oacc", oacc, held);
      if (iflush) begin
        beats.delete();
        expq.delete();
        hold_prev = 1'b0;
      end else begin
        if (ivalid && oready) begin
          beats.push_back(lanesum(idata));
          if (beats.size() == NP) begin
            expq.push_back(qsum(beats));
            beats.delete();
          end
        end
        if (ovalid && iready) begin
          if (expq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result actual=%0d expected=none", oacc);
          end else begin
            chk("oacc", oacc, expq.pop_front());
          end
          chk("ocount", ocount, ocnt_m);
          ocnt_m   = (ocnt_m + 1) & 16'hFFFF;
          ndeliv++;
          last_out = oacc;
        end
        hold_prev = ovalid && !iready;
        held      = oacc;
      end
    end
  end

  bit rnd_ready = 1'b0;
  initial forever begin
    @(posedge iclk);
    #1;
    if (rnd_ready) iready = ($urandom_range(0, 3) != 0);
  end

  int last_acc_cyc = 0;
  int waits = 0;

  task automatic send(input logic [16*DW-1:0] d);
    int n = 0;
    ivalid = 1'b1;
    idata  = d;
    @(negedge iclk);
    while (!oready && n < 300) begin
      n++;
      waits++;
      @(negedge iclk);
    end
    if (!oready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=oready0 expected=oready1");
    end
    @(posedge iclk);
    #1;
    last_acc_cyc = cyc;
    ivalid = 1'b0;
    idata  = rand_vec();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge iclk);
      #1;
      idata = rand_vec();
    end
  endtask

  task automatic wait_deliv(input int target);
    int n = 0;
    while (ndeliv < target && n < 300) begin
      @(negedge iclk);
      n++;
    end
    chk("delivered", ndeliv >= target, 1);
    @(posedge iclk);
    #1;
  endtask

  initial begin
    int base;
    int n;
    irst = 1'b1; ivalid = 1'b0; iflush = 1'b0; iready = 1'b1; idata = '0;
    @(posedge iclk);
    #1;
    chk("rst_oready", oready, 0);
    chk("rst_tree_en", otree_en, 0);
    chk("rst_ovalid", ovalid, 0);
    chk("rst_oacc", oacc, 0);
    chk("rst_opass", opass, 0);
    chk("rst_ocount", ocount, 0);
    @(posedge iclk);
    #1;
    irst = 1'b0;

    // 1: four all-ones vectors, latency and single-cycle pulse
    for (int i = 0; i < 4; i++) send(splat(1));
    n = 0;
    @(negedge iclk);
    while (!ovalid && n < 50) begin
      @(negedge iclk);
      n++;
    end
    chk("t1_latency", cyc - last_acc_cyc, LAT);
    chk("t1_oacc", oacc, 64);
    @(negedge iclk);
    chk("t1_pulse", ovalid, 0);
    chk("t1_ocount", ocount, 1);
    @(posedge iclk);
    #1;

    // 2: eight back-to-back max-value vectors
    waits = 0;
    base  = ndeliv;
    for (int i = 0; i < 8; i++) send(splat(255));
    chk("t2_no_wait", waits, 0);
    wait_deliv(base + 2);
    chk("t2_oacc", last_out, 16320);

    // 3: backpressure while streaming two groups
    iready = 1'b0;
    base   = ndeliv;
    fork
      begin
        for (int i = 0; i < 8; i++) send(rand_vec());
      end
      begin
        repeat (30) @(posedge iclk);
        #1;
        chk("t3_stall_oready", oready, 0);
        chk("t3_stall_tree_en", otree_en, 0);
        chk("t3_stall_ovalid", ovalid, 1);
        iready = 1'b1;
      end
    join
    wait_deliv(base + 2);

    // 4: bubbles between beats with random data on the bus
    base = ndeliv;
    send(splat(1)); idle(1);
    send(splat(2)); idle(1);
    send(splat(3)); idle(1);
    send(splat(4));
    wait_deliv(base + 1);
    chk("t4_oacc", last_out, 160);

    // 5: flush after two passes
    send(rand_vec());
    send(rand_vec());
    idle(LAT + 1);
    chk("t5_pass_mid", opass, 2);
    iflush = 1'b1;
    ivalid = 1'b1;
    idata  = rand_vec();
    @(posedge iclk);
    #1;
    iflush = 1'b0;
    ivalid = 1'b0;
    chk("t5_opass", opass, 0);
    chk("t5_ovalid", ovalid, 0);
    base = ndeliv;
    for (int i = 0; i < 4; i++) send(splat(1));
    wait_deliv(base + 1);
    chk("t5_oacc", last_out, 64);

    // 6: async reset while a result is held
    iready = 1'b0;
    for (int i = 0; i < 4; i++) send(rand_vec());
    n = 0;
    @(negedge iclk);
    while (!ovalid && n < 50) begin
      @(negedge iclk);
      n++;
    end
    chk("t6_ovalid_before", ovalid, 1);
    #1;
    irst = 1'b1;
    #1;
    chk("t6_ovalid", ovalid, 0);
    chk("t6_oacc", oacc, 0);
    chk("t6_opass", opass, 0);
    chk("t6_ocount", ocount, 0);
    chk("t6_oready", oready, 0);
    chk("t6_tree_en", otree_en, 0);
    @(posedge iclk);
    @(posedge iclk);
    #1;
    irst   = 1'b0;
    iready = 1'b1;
    base   = ndeliv;
    for (int i = 0; i < 4; i++) send(splat(1));
    wait_deliv(base + 1);
    chk("t6_oacc_after", last_out, 64);
    chk("t6_ocount_after", ocount, 1);

    // random traffic with random backpressure and gaps
    rnd_ready = 1'b1;
    repeat (120) begin
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      send(rand_vec());
    end
    rnd_ready = 1'b0;
    @(posedge iclk);
    #2;
    iready = 1'b1;
    n = 0;
    while ((expq.size() != 0 || ovalid) && n < 500) begin
      @(negedge iclk);
      n++;
    end
    chk("drain_expq", expq.size(), 0);
    chk("drain_partial", beats.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule
